game_master_param: RTL and testbench

GAME_MASTER_PARAM -- requirements
Module: game_master_param

---
 rtl/game_master_param.sv | 302 ++++++++++++++++++++++++++++++
 tb/tb_game_master_param.sv | 449 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/game_master_param.sv
// rtl/game_master_param.sv - bingo game master FSM; define GAME_TURN_TIMEOUT_EN to add the guess-turn timeout
module game_master_param #(
    parameter int  BOARD_N     = 5,
    parameter int  WIN_LINES   = 5,
    parameter int  TIMEOUT_CYC = 50_000_000,
    localparam int C           = BOARD_N * BOARD_N,
    localparam int NUM_W       = $clog2(C + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start_game,
    input  logic                 enter_pulse,
    input  logic [NUM_W-1:0]     num_in,
    output logic                 tx_valid,
    input  logic                 tx_ready,
    output logic [2:0]           tx_type,
    output logic [NUM_W-1:0]     tx_number,
    input  logic                 rx_valid,
    input  logic [2:0]           rx_type,
    input  logic [NUM_W-1:0]     rx_number,
    output logic [NUM_W*C-1:0]   map,
    output logic [C-1:0]         circle,
    output logic [3:0]           state,
    output logic                 err_pulse,
    output logic                 timeout_pulse
);

    localparam int IDXW = $clog2(C);
    localparam int LCW  = $clog2(2 * BOARD_N + 3);

    localparam logic [2:0] MSG_START = 3'd0;
    localparam logic [2:0] MSG_TURN  = 3'd1;
    localparam logic [2:0] MSG_SEL   = 3'd2;
    localparam logic [2:0] MSG_WIN   = 3'd3;

    if (BOARD_N < 3 || BOARD_N > 7 || WIN_LINES < 1 || WIN_LINES > 2 * BOARD_N + 2 ||
        TIMEOUT_CYC < 1) begin : g_bad_params
        $error("game_master_param: parameter out of legal range");
    end

    // State codes follow the listed order, IDLE = 0 through FIN = 11.
    typedef enum logic [3:0] {
        IDLE        = 4'd0,
        SEND_START  = 4'd1,
        SEL         = 4'd2,
        SEND_TURN   = 4'd3,
        WAIT_P2_SEL = 4'd4,
        GUESS       = 4'd5,
        CHECK_L     = 4'd6,
        SEND_SEL    = 4'd7,
        SEND_WIN    = 4'd8,
        WAIT_P2     = 4'd9,
        CHECK_R     = 4'd10,
        FIN         = 4'd11
    } state_t;

    state_t             state_q, state_d;
    logic [NUM_W*C-1:0] map_q;
    logic [C-1:0]       circle_q;
    logic [NUM_W-1:0]   sel_idx_q;
    logic [NUM_W-1:0]   last_num_q;

    logic               num_ok, rx_ok;
    logic               num_hit, rx_hit;
    logic [IDXW-1:0]    num_idx, rx_idx;
    logic [BOARD_N-1:0] row_full, col_full;
    logic [1:0]         diag_full;
    logic [LCW-1:0]     line_cnt;
    logic               win;

    logic               do_place, do_mark, set_err, clear_all;
    logic [IDXW-1:0]    mark_idx;
    logic [NUM_W-1:0]   mark_num;

    assign map    = map_q;
    assign circle = circle_q;
    assign state  = state_q;

    assign num_ok = (num_in != '0) && (num_in <= NUM_W'(C));
    assign rx_ok  = (rx_number != '0) && (rx_number <= NUM_W'(C));

    // Locate the cells holding num_in and rx_number; unfilled cells hold 0 so never match a legal number.
    always_comb begin
        num_hit = 1'b0;
        rx_hit  = 1'b0;
        num_idx = '0;
        rx_idx  = '0;
        for (int i = 0; i < C; i++) begin
            if (map_q[i*NUM_W +: NUM_W] == num_in) begin
                num_hit = 1'b1;
                num_idx = IDXW'(i);
            end
            if (map_q[i*NUM_W +: NUM_W] == rx_number) begin
                rx_hit = 1'b1;
                rx_idx = IDXW'(i);
            end
        end
    end

    // Count completed rows, columns and both diagonals from the registered circle bits.
    always_comb begin
        row_full  = '1;
        col_full  = '1;
        diag_full = '1;
        for (int r = 0; r < BOARD_N; r++) begin
            for (int c = 0; c < BOARD_N; c++) begin
                if (!circle_q[r*BOARD_N+c]) begin
                    row_full[r] = 1'b0;
                    col_full[c] = 1'b0;
                end
            end
            if (!circle_q[r*BOARD_N+r])
                diag_full[0] = 1'b0;
            if (!circle_q[r*BOARD_N+(BOARD_N-1-r)])
                diag_full[1] = 1'b0;
        end
        line_cnt = LCW'(diag_full[0]) + LCW'(diag_full[1]);
        for (int i = 0; i < BOARD_N; i++)
            line_cnt = line_cnt + LCW'(row_full[i]) + LCW'(col_full[i]);
    end

    assign win = (line_cnt >= LCW'(WIN_LINES));

`ifdef GAME_TURN_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    logic [TW-1:0]   timer_q;
    logic            timer_hit;
    logic            free_hit;
    logic [IDXW-1:0] free_idx;
    logic            set_tout;

    assign timer_hit = (timer_q == TW'(TIMEOUT_CYC - 1));

    // Find the lowest-index unmarked cell for the automatic guess.
    always_comb begin
        free_hit = 1'b0;
        free_idx = '0;
        for (int i = C - 1; i >= 0; i--) begin
            if (!circle_q[i]) begin
                free_hit = 1'b1;
                free_idx = IDXW'(i);
            end
        end
    end

    // Guess-turn timer: zero outside GUESS, so it restarts on every entry into GUESS.
    always_ff @(posedge clk) begin
        if (rst || state_q != GUESS)
            timer_q <= '0;
        else
            timer_q <= timer_q + 1'b1;
    end

    // One-cycle flag marking an automatic guess.
    always_ff @(posedge clk) begin
        if (rst)
            timeout_pulse <= 1'b0;
        else
            timeout_pulse <= set_tout;
    end
`else
    assign timeout_pulse = 1'b0;
`endif

    // Next-state, board update requests and outbound message fields.
    always_comb begin
        state_d   = state_q;
        do_place  = 1'b0;
        do_mark   = 1'b0;
        mark_idx  = '0;
        mark_num  = '0;
        set_err   = 1'b0;
        clear_all = 1'b0;
        tx_valid  = 1'b0;
        tx_type   = MSG_START;
        tx_number = '0;
`ifdef GAME_TURN_TIMEOUT_EN
        set_tout  = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (start_game)
                    state_d = SEND_START;
            end
            SEND_START: begin
                tx_valid = 1'b1;
                tx_type  = MSG_START;
                if (tx_ready)
                    state_d = SEL;
            end
            SEL: begin
                if (enter_pulse) begin
                    if (num_ok && !num_hit) begin
                        do_place = 1'b1;
                        if (sel_idx_q == NUM_W'(C - 1))
                            state_d = SEND_TURN;
                    end else begin
                        set_err = 1'b1;
                    end
                end
            end
            SEND_TURN: begin
                tx_valid = 1'b1;
                tx_type  = MSG_TURN;
                if (tx_ready)
                    state_d = WAIT_P2_SEL;
            end
            WAIT_P2_SEL: begin
                if (rx_valid && rx_type == MSG_TURN)
                    state_d = GUESS;
            end
            GUESS: begin
                if (enter_pulse && num_ok && num_hit && !circle_q[num_idx]) begin
                    do_mark  = 1'b1;
                    mark_idx = num_idx;
                    mark_num = num_in;
                    state_d  = CHECK_L;
                end else begin
                    set_err = enter_pulse;
`ifdef GAME_TURN_TIMEOUT_EN
                    if (timer_hit && free_hit) begin
                        do_mark  = 1'b1;
                        mark_idx = free_idx;
                        mark_num = map_q[int'(free_idx)*NUM_W +: NUM_W];
                        set_tout = 1'b1;
                        state_d  = CHECK_L;
                    end
`endif
                end
            end
            CHECK_L: begin
                state_d = win ? SEND_WIN : SEND_SEL;
            end
            SEND_SEL: begin
                tx_valid  = 1'b1;
                tx_type   = MSG_SEL;
                tx_number = last_num_q;
                if (tx_ready)
                    state_d = WAIT_P2;
            end
            SEND_WIN: begin
                tx_valid  = 1'b1;
                tx_type   = MSG_WIN;
                tx_number = last_num_q;
                if (tx_ready)
                    state_d = FIN;
            end
            WAIT_P2: begin
                if (rx_valid) begin
                    if (rx_type == MSG_SEL && rx_ok && rx_hit) begin
                        do_mark  = 1'b1;
                        mark_idx = rx_idx;
                        mark_num = rx_number;
                        state_d  = CHECK_R;
                    end else if (rx_type == MSG_WIN) begin
                        state_d = FIN;
                    end
                end
            end
            CHECK_R: begin
                state_d = win ? SEND_WIN : GUESS;
            end
            FIN: begin
                if (start_game) begin
                    clear_all = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register, board storage and the rejected-entry flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            map_q      <= '0;
            circle_q   <= '0;
            sel_idx_q  <= '0;
            last_num_q <= '0;
            err_pulse  <= 1'b0;
        end else begin
            state_q   <= state_d;
            err_pulse <= set_err;
            if (clear_all) begin
                map_q     <= '0;
                circle_q  <= '0;
                sel_idx_q <= '0;
            end
            if (do_place) begin
                map_q[int'(sel_idx_q)*NUM_W +: NUM_W] <= num_in;
                sel_idx_q <= sel_idx_q + 1'b1;
            end
            if (do_mark) begin
                circle_q[mark_idx] <= 1'b1;
                last_num_q         <= mark_num;
            end
        end
    end

endmodule

// File: tb/tb_game_master_param.sv
// tb/tb_game_master_param.sv - self-checking bench for game_master_param
module tb_game_master_param;

    localparam int N  = 5;
    localparam int C  = N * N;
    localparam int NW = 5;
    localparam int WL = 1;
    localparam int TO = 8;

    localparam int S_IDLE = 0, S_SEND_START = 1, S_SEL = 2, S_SEND_TURN = 3;
    localparam int S_WAIT_P2_SEL = 4, S_GUESS = 5, S_CHECK_L = 6, S_SEND_SEL = 7;
    localparam int S_SEND_WIN = 8, S_WAIT_P2 = 9, S_CHECK_R = 10, S_FIN = 11;
    localparam int T_START = 0, T_TURN = 1, T_SEL = 2, T_WIN = 3;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            start_game = 1'b0;
    logic            enter_pulse = 1'b0;
    logic [NW-1:0]   num_in = '0;
    logic            tx_valid;
    logic            tx_ready = 1'b1;
    logic [2:0]      tx_type;
    logic [NW-1:0]   tx_number;
    logic            rx_valid = 1'b0;
    logic [2:0]      rx_type = '0;
    logic [NW-1:0]   rx_number = '0;
    logic [NW*C-1:0] map;
    logic [C-1:0]    circle;
    logic [3:0]      state;
    logic            err_pulse;
    logic            timeout_pulse;

    int checks = 0;
    int errors = 0;
    int m_map[C];
    bit m_circ[C];

    typedef struct {
        int num;
        bit err;
        int st;
    } sel_vec_t;

    sel_vec_t sel_tab[$];

    game_master_param #(
        .BOARD_N(N),
        .WIN_LINES(WL),
        .TIMEOUT_CYC(TO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start_game(start_game),
        .enter_pulse(enter_pulse),
        .num_in(num_in),
        .tx_valid(tx_valid),
        .tx_ready(tx_ready),
        .tx_type(tx_type),
        .tx_number(tx_number),
        .rx_valid(rx_valid),
        .rx_type(rx_type),
        .rx_number(rx_number),
        .map(map),
        .circle(circle),
        .state(state),
        .err_pulse(err_pulse),
        .timeout_pulse(timeout_pulse)
    );

    always #5 clk = ~clk;

    initial begin
        #600000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic int model_lines();
        int n = 0;
        bit fr, fc, d0 = 1, d1 = 1;
        for (int a = 0; a < N; a++) begin
            fr = 1;
            fc = 1;
            for (int b = 0; b < N; b++) begin
                if (!m_circ[a*N+b]) fr = 0;
                if (!m_circ[b*N+a]) fc = 0;
            end
            n += int'(fr) + int'(fc);
            if (!m_circ[a*N+a]) d0 = 0;
            if (!m_circ[a*N+(N-1-a)]) d1 = 0;
        end
        return n + int'(d0) + int'(d1);
    endfunction

    function automatic logic [NW*C-1:0] model_map();
        logic [NW*C-1:0] f = '0;
        for (int i = 0; i < C; i++) f[i*NW +: NW] = NW'(m_map[i]);
        return f;
    endfunction

    function automatic logic [C-1:0] model_circ();
        logic [C-1:0] f = '0;
        for (int i = 0; i < C; i++) f[i] = m_circ[i];
        return f;
    endfunction

    task automatic clear_model();
        for (int i = 0; i < C; i++) begin
            m_map[i]  = 0;
            m_circ[i] = 0;
        end
    endtask

    task automatic enter_chk(input int num, input bit exp_err, input int exp_st, input string nm);
        enter_pulse = 1'b1;
        num_in = NW'(num);
        tick();
        enter_pulse = 1'b0;
        chk({nm, "_err"}, err_pulse, exp_err);
        chk({nm, "_state"}, state, exp_st);
        chk({nm, "_tout"}, timeout_pulse, 1'b0);
    endtask

    task automatic rx_send(input int t, input int num);
        rx_valid = 1'b1;
        rx_type = 3'(t);
        rx_number = NW'(num);
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic get_msg(input int et, input int en, input string nm);
        bit got = 0;
        for (int n = 0; n < 64 && !got; n++) begin
            tx_ready = ($urandom_range(0, 2) != 0);
            if (tx_valid && tx_ready) begin
                chk({nm, "_type"}, tx_type, et);
                if (en >= 0) chk({nm, "_num"}, tx_number, en);
                got = 1;
            end
            tick();
        end
        tx_ready = 1'b1;
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got no message expected type %0d", nm, et);
        end
    endtask

    task automatic remote_sel(input int num, input string nm);
        rx_send(T_SEL, num);
        chk({nm, "_state"}, state, S_CHECK_R);
        chk({nm, "_circle"}, circle, model_circ());
    endtask

    // From IDLE: start, place 1..C in order, exchange TURN, arrive in GUESS.
    task automatic quick_setup();
        clear_model();
        start_game = 1'b1;
        tick();
        start_game = 1'b0;
        get_msg(T_START, 0, "qs_start");
        for (int v = 1; v <= C; v++) begin
            m_map[v-1] = v;
            enter_chk(v, 0, (v == C) ? S_SEND_TURN : S_SEL, "qs_sel");
        end
        get_msg(T_TURN, -1, "qs_turn");
        rx_send(T_TURN, 0);
        chk("qs_guess", state, S_GUESS);
    endtask

    task automatic play_random_game();
        int perm[C];
        int cand[$];
        bit over = 0;
        tick();
        chk("rg_state_start", state, S_SEND_START);
        get_msg(T_START, 0, "rg_start");
        clear_model();
        for (int i = 0; i < C; i++) perm[i] = i + 1;
        for (int i = C - 1; i > 0; i--) begin
            int j = $urandom_range(0, i);
            int t = perm[i];
            perm[i] = perm[j];
            perm[j] = t;
        end
        for (int k = 0; k < C; k++) begin
            if ($urandom_range(0, 3) == 0) begin
                int bad;
                case ($urandom_range(0, 2))
                    0: bad = 0;
                    1: bad = $urandom_range(C + 1, (1 << NW) - 1);
                    default: bad = (k > 0) ? perm[$urandom_range(0, k - 1)] : 0;
                endcase
                start_game = 1'($urandom_range(0, 1));
                enter_chk(bad, 1, S_SEL, "rg_sel_bad");
            end
            start_game = 1'($urandom_range(0, 1));
            m_map[k] = perm[k];
            enter_chk(perm[k], 0, (k == C - 1) ? S_SEND_TURN : S_SEL, "rg_sel");
        end
        start_game = 1'b0;
        chk("rg_map", map, model_map());
        get_msg(T_TURN, -1, "rg_turn");
        rx_send(T_SEL, $urandom_range(1, C));
        chk("rg_wait_sel_ignore", state, S_WAIT_P2_SEL);
        chk("rg_wait_sel_circle", circle, '0);
        rx_send(T_TURN, 0);
        chk("rg_to_guess", state, S_GUESS);
        for (int turn = 0; turn < C && !over; turn++) begin
            int n;
            repeat ($urandom_range(0, 3)) tick();
            if ($urandom_range(0, 2) == 0) begin
                int bad = 0;
                for (int i = 0; i < C; i++) if (m_circ[i]) bad = m_map[i];
                enter_chk(bad, 1, S_GUESS, "rg_guess_bad");
            end
            cand.delete();
            for (int i = 0; i < C; i++) if (!m_circ[i]) cand.push_back(i);
            if (cand.size() == 0) break;
            n = cand[$urandom_range(0, cand.size() - 1)];
            m_circ[n] = 1;
            enter_chk(m_map[n], 0, S_CHECK_L, "rg_guess");
            chk("rg_guess_circle", circle, model_circ());
            if (model_lines() >= WL) begin
                get_msg(T_WIN, m_map[n], "rg_win_local");
                chk("rg_fin_local", state, S_FIN);
                over = 1;
            end else begin
                get_msg(T_SEL, m_map[n], "rg_sel_msg");
                chk("rg_wait_p2", state, S_WAIT_P2);
                if ($urandom_range(0, 1) == 1) begin
                    int t = $urandom_range(0, 5);
                    if (t >= 2) t = t + 2;
                    if ($urandom_range(0, 1) == 1)
                        rx_send(T_SEL, ($urandom_range(0, 1) == 1) ? 0 : $urandom_range(C + 1, (1 << NW) - 1));
                    else
                        rx_send(t, $urandom_range(1, C));
                    chk("rg_noise_state", state, S_WAIT_P2);
                    chk("rg_noise_circle", circle, model_circ());
                end
                if ($urandom_range(0, 9) == 0) begin
                    rx_send(T_WIN, 0);
                    chk("rg_fin_remote_win", state, S_FIN);
                    over = 1;
                end else begin
                    int r = $urandom_range(0, C - 1);
                    m_circ[r] = 1;
                    remote_sel(m_map[r], "rg_remote");
                    if (model_lines() >= WL) begin
                        get_msg(T_WIN, m_map[r], "rg_win_remote");
                        chk("rg_fin_remote", state, S_FIN);
                        over = 1;
                    end else begin
                        tick();
                        chk("rg_back_guess", state, S_GUESS);
                    end
                end
            end
        end
        chk("rg_over", over, 1'b1);
    endtask

    initial begin
        int err_cnt = 0;

        // Table of SEL-phase entries: 1..7, a duplicate 7, then 8..25.
        for (int v = 1; v <= C; v++) begin
            sel_vec_t e;
            e.num = v;
            e.err = 0;
            e.st  = (v == C) ? S_SEND_TURN : S_SEL;
            sel_tab.push_back(e);
            if (v == 7) begin
                e.err = 1;
                sel_tab.push_back(e);
            end
        end

        // Reset with busy inputs
        start_game = 1'b1;
        rx_valid = 1'b1;
        enter_pulse = 1'b1;
        tick();
        tick();
        chk("rst_state", state, S_IDLE);
        chk("rst_tx_valid", tx_valid, 1'b0);
        chk("rst_tx_type", tx_type, 3'd0);
        chk("rst_tx_number", tx_number, '0);
        chk("rst_map", map, '0);
        chk("rst_circle", circle, '0);
        chk("rst_err", err_pulse, 1'b0);
        chk("rst_tout", timeout_pulse, 1'b0);
        rx_valid = 1'b0;
        enter_pulse = 1'b0;
        start_game = 1'b0;
        rst = 1'b0;

        // Start handshake with tx_ready held high
        tx_ready = 1'b1;
        start_game = 1'b1;
        tick();
        start_game = 1'b0;
        chk("start_state", state, S_SEND_START);
        chk("start_valid", tx_valid, 1'b1);
        chk("start_type", tx_type, T_START);
        chk("start_num", tx_number, 0);
        tick();
        chk("start_to_sel", state, S_SEL);

        // Board fill from the table
        clear_model();
        for (int i = 0; i < sel_tab.size(); i++) begin
            enter_chk(sel_tab[i].num, sel_tab[i].err, sel_tab[i].st, $sformatf("tab%0d", i));
            if (err_pulse) err_cnt++;
        end
        for (int i = 0; i < C; i++) m_map[i] = i + 1;
        chk("tab_err_once", err_cnt, 1);
        chk("tab_map", map, model_map());
        get_msg(T_TURN, -1, "tab_turn");
        chk("tab_wait_sel", state, S_WAIT_P2_SEL);
        enter_chk(9, 0, S_WAIT_P2_SEL, "enter_ignored_wait");
        rx_send(T_SEL, 3);
        chk("wait_sel_ignore", state, S_WAIT_P2_SEL);
        rx_send(T_TURN, 0);
        chk("to_guess", state, S_GUESS);

        // Guess 1 with tx_ready low for 10 cycles in SEND_SEL
        m_circ[0] = 1;
        enter_chk(1, 0, S_CHECK_L, "g1");
        tx_ready = 1'b0;
        tick();
        for (int k = 0; k < 10; k++) begin
            chk("stall_state", state, S_SEND_SEL);
            chk("stall_valid", tx_valid, 1'b1);
            chk("stall_type", tx_type, T_SEL);
            chk("stall_num", tx_number, 1);
            tick();
        end
        tx_ready = 1'b1;
        chk("stall_valid_last", tx_valid, 1'b1);
        tick();
        chk("stall_release", state, S_WAIT_P2);
        enter_chk(10, 0, S_WAIT_P2, "enter_ignored_p2");
        start_game = 1'b1;
        tick();
        start_game = 1'b0;
        chk("start_ignored_p2", state, S_WAIT_P2);

        // Guesses 2..4 against remote 25, 24, 23, then remote 5 completes row 0
        for (int g = 2; g <= 4; g++) begin
            m_circ[C-g+1] = 1;
            remote_sel(C - g + 2, "hand_remote");
            tick();
            chk("hand_guess", state, S_GUESS);
            m_circ[g-1] = 1;
            enter_chk(g, 0, S_CHECK_L, "hand_g");
            get_msg(T_SEL, g, "hand_sel");
        end
        m_circ[4] = 1;
        remote_sel(5, "row0_remote");
        get_msg(T_WIN, 5, "row0_win");
        chk("row0_fin", state, S_FIN);

        // FIN clears the board
        start_game = 1'b1;
        tick();
        start_game = 1'b0;
        chk("fin_idle", state, S_IDLE);
        chk("fin_map", map, '0);
        chk("fin_circle", circle, '0);
        tick();
        chk("idle_hold", state, S_IDLE);

        // Guess-turn timeout with cells 0 and 1 marked
        quick_setup();
        m_circ[0] = 1;
        enter_chk(1, 0, S_CHECK_L, "to_g1");
        get_msg(T_SEL, 1, "to_sel1");
        m_circ[1] = 1;
        remote_sel(2, "to_remote2");
        tick();
        chk("to_guess_entry", state, S_GUESS);
        repeat (7) tick();
        chk("to_guess_7", state, S_GUESS);
        chk("to_no_pulse_7", timeout_pulse, 1'b0);
        tick();
        m_circ[2] = 1;
`ifdef GAME_TURN_TIMEOUT_EN
        chk("to_fire_state", state, S_CHECK_L);
        chk("to_fire_pulse", timeout_pulse, 1'b1);
        chk("to_fire_circle", circle, model_circ());
        tick();
        chk("to_pulse_one_cycle", timeout_pulse, 1'b0);
`else
        chk("to_off_state", state, S_GUESS);
        chk("to_off_pulse", timeout_pulse, 1'b0);
        enter_chk(3, 0, S_CHECK_L, "to_off_g3");
`endif
        get_msg(T_SEL, 3, "to_sel3");
        chk("to_wait_p2", state, S_WAIT_P2);

        // Reset in WAIT_P2 with a simultaneous inbound message
        rx_valid = 1'b1;
        rx_type = 3'(T_SEL);
        rx_number = NW'(10);
        rst = 1'b1;
        tick();
        rx_valid = 1'b0;
        chk("rst_mid_state", state, S_IDLE);
        chk("rst_mid_circle", circle, '0);
        chk("rst_mid_map", map, '0);
        chk("rst_mid_valid", tx_valid, 1'b0);
        rst = 1'b0;
        tick();
        chk("rst_mid_after", state, S_IDLE);
        chk("rst_mid_after_circle", circle, '0);

        // Randomized games against the model
        start_game = 1'b1;
        for (int g = 0; g < 6; g++) begin
            play_random_game();
            start_game = 1'b1;
            tick();
            chk("rg_idle", state, S_IDLE);
            chk("rg_clear_map", map, '0);
            chk("rg_clear_circle", circle, '0);
        end
        start_game = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
